// File: rtl/eca_engine_if.sv
// Handshake, control and readout bundle for eca_engine.
// master: the side that loads, starts and reads; slave: the engine.
interface eca_engine_if #(
  parameter int NUM_CELLS = 128,
  parameter int GEN_W     = 16
);
  localparam int BANK_W = $clog2(NUM_CELLS / 8);

  logic [7:0]        rule;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;
  logic              start;
  logic [GEN_W-1:0]  gen_limit;
  logic              stop;
  logic              busy;
  logic              done;
  logic [GEN_W-1:0]  generation;
  logic [BANK_W-1:0] rd_bank;
  logic [7:0]        rd_data;

  modport master (
    output rule, load_valid, load_data, start, gen_limit, stop, rd_bank,
    input  load_ready, busy, done, generation, rd_data
  );

  modport slave (
    input  rule, load_valid, load_data, start, gen_limit, stop, rd_bank,
    output load_ready, busy, done, generation, rd_data
  );
endinterface

// File: rtl/eca_engine.sv
// Elementary cellular automaton engine: byte-wise load, rule-driven run, byte readout.
// Optional macro ECA_WRAP_AROUND_EN turns the cell row into a ring; otherwise edges read 0.
module eca_engine #(
  parameter int NUM_CELLS = 128,
  parameter int GEN_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  eca_engine_if.slave bus
);
  localparam int NUM_BANKS = NUM_CELLS / 8;
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  logic [NUM_CELLS-1:0] cells_r;
  logic [BANK_W-1:0]    ptr_r;
  logic [7:0]           rule_r;
  logic [GEN_W-1:0]     gen_limit_r;
  logic [GEN_W-1:0]     generation_r;
  logic                 done_r;
  logic [7:0]           rd_data_r;

  logic                 edge_lo_s;
  logic                 edge_hi_s;
  logic [NUM_CELLS+1:0] ext_s;
  logic [NUM_CELLS-1:0] next_cells_s;
  logic [GEN_W-1:0]     gen_inc_s;
  logic                 limit_hit_s;

`ifdef ECA_WRAP_AROUND_EN
  assign edge_lo_s = cells_r[NUM_CELLS-1];
  assign edge_hi_s = cells_r[0];
`else
  assign edge_lo_s = 1'b0;
  assign edge_hi_s = 1'b0;
`endif

  // ext_s[0] is neighbour cell -1, ext_s[NUM_CELLS+1] is neighbour cell NUM_CELLS
  assign ext_s       = {edge_hi_s, cells_r, edge_lo_s};
  assign gen_inc_s   = generation_r + GEN_W'(1);
  assign limit_hit_s = (gen_limit_r != {GEN_W{1'b0}}) && (gen_inc_s == gen_limit_r);

  // Next generation: every cell looks up rule_r with {right, self, left}
  always_comb begin
    next_cells_s = {NUM_CELLS{1'b0}};
    for (int i = 0; i < NUM_CELLS; i++) begin
      next_cells_s[i] = rule_r[ext_s[i +: 3]];
    end
  end

  // Control FSM together with cell, pointer and generation state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cells_r      <= {NUM_CELLS{1'b0}};
      ptr_r        <= {BANK_W{1'b0}};
      rule_r       <= 8'h00;
      gen_limit_r  <= {GEN_W{1'b0}};
      generation_r <= {GEN_W{1'b0}};
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            rule_r       <= bus.rule;
            gen_limit_r  <= bus.gen_limit;
            generation_r <= {GEN_W{1'b0}};
            ptr_r        <= {BANK_W{1'b0}};
            state_r      <= ST_RUN;
          end else if (bus.load_valid) begin
            cells_r[{ptr_r, 3'b000} +: 8] <= bus.load_data;
            if (ptr_r == BANK_W'(NUM_BANKS - 1)) begin
              ptr_r <= {BANK_W{1'b0}};
            end else begin
              ptr_r <= ptr_r + BANK_W'(1);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // stop takes priority over both the update and a limit hit
          if (bus.stop) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end else begin
            cells_r      <= next_cells_s;
            generation_r <= gen_inc_s;
            if (limit_hit_s) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Readout register, refreshed every cycle in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= 8'h00;
    end else begin
      rd_data_r <= cells_r[{bus.rd_bank, 3'b000} +: 8];
    end
  end

  assign bus.busy       = (state_r == ST_RUN);
  assign bus.load_ready = (state_r == ST_IDLE) && !bus.start;
  assign bus.done       = done_r;
  assign bus.generation = generation_r;
  assign bus.rd_data    = rd_data_r;
endmodule

// File: tb/tb_eca_engine.sv
// Self-checking bench for eca_engine: bench-side automaton model plus a readout scoreboard.
module tb_eca_engine;
  localparam int N  = 128;
  localparam int GW = 16;
  localparam int NB = N / 8;
  localparam int BW = $clog2(NB);

  logic clk = 1'b0;
  logic reset;

  eca_engine_if #(.NUM_CELLS(N), .GEN_W(GW)) bus ();
  eca_engine #(.NUM_CELLS(N), .GEN_W(GW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] m_cells;
  int m_ptr;
  logic [7:0] exp_q[$];

  // Reference step, written cell by cell from the rule definition
  function automatic logic [N-1:0] ref_step(input logic [N-1:0] c, input logic [7:0] r);
    logic [N-1:0] nx;
    logic l, s, rt;
    for (int i = 0; i < N; i++) begin
      s = c[i];
      if (i == 0) begin
`ifdef ECA_WRAP_AROUND_EN
        l = c[N-1];
`else
        l = 1'b0;
`endif
      end else l = c[i-1];
      if (i == N - 1) begin
`ifdef ECA_WRAP_AROUND_EN
        rt = c[0];
`else
        rt = 1'b0;
`endif
      end else rt = c[i+1];
      nx[i] = r[{rt, s, l}];
    end
    return nx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cells = '0;
    m_ptr = 0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    tick();
    bus.load_valid = 1'b0;
    m_cells[8*m_ptr +: 8] = b;
    m_ptr = (m_ptr + 1) % NB;
  endtask

  task automatic read_all(input string name);
    logic [7:0] e;
    for (int b = 0; b < NB; b++) begin
      bus.rd_bank = BW'(b);
      exp_q.push_back(m_cells[8*b +: 8]);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (bus.rd_data !== e) begin
        errors++;
        $display("FAIL %s bank %0d: got %h expected %h", name, b, bus.rd_data, e);
      end
    end
  endtask

  task automatic read_bank(input string name, input int b, input logic [7:0] e);
    bus.rd_bank = BW'(b);
    tick();
    chk(name, {24'h0, bus.rd_data}, {24'h0, e});
  endtask

  // Runs to a nonzero limit and checks busy length, single done and final generation
  task automatic run_limit(input string name, input logic [7:0] r, input logic [GW-1:0] lim);
    int cyc = 0;
    int dn = 0;
    bus.rule = r;
    bus.gen_limit = lim;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_ptr = 0;
    while (bus.busy === 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) dn++;
    end
    chk({name, " busy_cycles"}, cyc, 32'(lim));
    chk({name, " done_pulses"}, dn, 32'd1);
    chk({name, " generation"}, {16'h0, bus.generation}, {16'h0, lim});
    tick();
    chk({name, " done_cleared"}, {31'h0, bus.done}, 32'd0);
    for (int k = 0; k < int'(lim); k++) m_cells = ref_step(m_cells, r);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hFF;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    chk("reset load_ready", {31'h0, bus.load_ready}, 32'd1);
    tick();
    reset = 1'b0;
    m_cells = '0;
    m_ptr = 0;
    chk("reset busy", {31'h0, bus.busy}, 32'd0);
    chk("reset done", {31'h0, bus.done}, 32'd0);
    chk("reset generation", {16'h0, bus.generation}, 32'd0);
    chk("reset rd_data", {24'h0, bus.rd_data}, 32'd0);
    read_all("reset cells");
  endtask

  task automatic test_rule110();
    do_reset();
    load_byte(8'h01);
    for (int b = 1; b < NB; b++) load_byte(8'h00);
    run_limit("rule110", 8'h6E, 16'd1);
    read_bank("rule110 bank0", 0, 8'h03);
    read_all("rule110 cells");
  endtask

  task automatic test_edges();
    logic [7:0] e0;
    do_reset();
    for (int b = 0; b < NB - 1; b++) load_byte(8'h00);
    load_byte(8'h80);
    run_limit("edge", 8'h02, 16'd1);
`ifdef ECA_WRAP_AROUND_EN
    e0 = 8'h01;
`else
    e0 = 8'h00;
`endif
    read_bank("edge bank0", 0, e0);
    read_bank("edge bank15", NB - 1, 8'h00);
    read_all("edge cells");
  endtask

  task automatic test_stop();
    int dn = 0;
    do_reset();
    for (int b = 0; b < NB; b++) load_byte(8'hA5);
    bus.rule = 8'hCC;
    bus.gen_limit = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_ptr = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) begin
        bus.rule = 8'h00;
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      bus.rule = 8'hCC;
      if (bus.done === 1'b1) dn++;
      m_cells = ref_step(m_cells, 8'hCC);
    end
    chk("stop busy_before", {31'h0, bus.busy}, 32'd1);
    chk("stop gen_before", {16'h0, bus.generation}, 32'd10);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    if (bus.done === 1'b1) dn++;
    chk("stop busy_after", {31'h0, bus.busy}, 32'd0);
    chk("stop generation", {16'h0, bus.generation}, 32'd10);
    tick();
    if (bus.done === 1'b1) dn++;
    chk("stop done_pulses", dn, 32'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop idle done", {31'h0, bus.done}, 32'd0);
    chk("stop idle generation", {16'h0, bus.generation}, 32'd10);
    read_all("stop cells");
  endtask

  task automatic test_start_load();
    int cyc = 0;
    do_reset();
    bus.rule = 8'hCC;
    bus.gen_limit = 16'd3;
    bus.start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hFF;
    #1;
    chk("start_load ready", {31'h0, bus.load_ready}, 32'd0);
    tick();
    bus.start = 1'b0;
    chk("start_load run_ready", {31'h0, bus.load_ready}, 32'd0);
    while (bus.busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    bus.load_valid = 1'b0;
    chk("start_load cycles", cyc, 32'd3);
    m_ptr = 0;
    load_byte(8'h3C);
    read_all("start_load cells");
  endtask

  task automatic test_reset_mid_run();
    int dn = 0;
    do_reset();
    for (int b = 0; b < NB; b++) load_byte(8'h5A);
    bus.rule = 8'hCC;
    bus.gen_limit = 16'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (40) tick();
    chk("midrst gen40", {16'h0, bus.generation}, 32'd40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_cells = '0;
    m_ptr = 0;
    if (bus.done === 1'b1) dn++;
    chk("midrst busy", {31'h0, bus.busy}, 32'd0);
    chk("midrst generation", {16'h0, bus.generation}, 32'd0);
    tick();
    if (bus.done === 1'b1) dn++;
    chk("midrst no_done", dn, 32'd0);
    read_all("midrst cells");
  endtask

  task automatic test_rd_latency();
    do_reset();
    for (int b = 0; b < NB; b++) load_byte(8'(b * 17 + 1));
    read_bank("rdlat bank0", 0, 8'h01);
    bus.rd_bank = BW'(3);
    #1;
    chk("rdlat still bank0", {24'h0, bus.rd_data}, 32'h01);
    tick();
    chk("rdlat bank3", {24'h0, bus.rd_data}, 32'd52);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int b = 0; b < NB; b++) load_byte(8'h11);
    load_byte(8'hC3);
    read_all("ptr_wrap cells");
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int b = 0; b < NB; b++) load_byte(8'($urandom));
      run_limit("random run", 8'($urandom), 16'($urandom_range(1, 6)));
      read_all("random cells");
      run_limit("chained run", 8'h6E, 16'd2);
      read_all("chained cells");
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rule = 8'h00;
    bus.load_valid = 1'b0;
    bus.load_data = 8'h00;
    bus.start = 1'b0;
    bus.gen_limit = 16'd0;
    bus.stop = 1'b0;
    bus.rd_bank = '0;
    m_cells = '0;
    m_ptr = 0;
    tick();
    test_reset();
    test_rule110();
    test_edges();
    test_stop();
    test_start_load();
    test_reset_mid_run();
    test_rd_latency();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
